// File: rtl/skew_stream_seq_pkg.sv
// skew_stream_seq_pkg: shared types and helpers for the skewed lane-release sequencer.
//   state_t : sequencer state encoding (IDLE, RUN)
//   clog2   : ceiling log2 used to size the cycle counter
package skew_stream_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Returns ceil(log2(v)); 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r_bits;
        int unsigned r_val;
        r_bits = 0;
        r_val  = (v > 0) ? v - 1 : 0;
        while (r_val > 0) begin
            r_bits = r_bits + 1;
            r_val  = r_val >> 1;
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/skew_stream_seq_lane_gate.sv
// skew_lane_gate: window compare for one lane.
//   i_c    : cycle counter value for the coming cycle
//   i_r    : release offset of this lane
//   i_len  : number of cycles the lane stays released
//   o_rst  : 0 while i_r <= i_c <= i_r+i_len-1, else 1 (next-cycle lane reset)
module skew_lane_gate #(
    parameter int unsigned CNT_W = 1
) (
    input  logic [CNT_W-1:0] i_c,
    input  logic [CNT_W-1:0] i_r,
    input  logic [CNT_W:0]   i_len,
    output logic             o_rst
);

    logic [CNT_W:0] w_off;
    logic           w_in_win;

    // Offset is only meaningful when i_c >= i_r; the extra bit keeps the
    // compare against i_len free of overflow.
    assign w_off    = {1'b0, i_c} - {1'b0, i_r};
    assign w_in_win = (i_c >= i_r) && (w_off < i_len);
    assign o_rst    = ~w_in_win;

endmodule

// File: rtl/skew_stream_seq.sv
// skew_stream_seq: releases LANES input-mux resets in a staggered sequence,
// lane LANES-1 first, each lane held released for BLOCK_LEN cycles.
//   clock     : clock, all state changes on rising edge
//   reset     : synchronous active-low reset
//   start     : run one block (sampled only in IDLE)
//   abort     : terminate a running block, no completion
//   repeat_en : at end of block, start the next block back-to-back
//   lane_rst  : registered per-lane reset (1 = held, 0 = released)
//   ready     : high in IDLE
//   busy      : high in RUN
//   done      : one-cycle pulse after a block completes
//   block_cnt : completed-block count, wraps at 255
module skew_stream_seq
    import skew_stream_seq_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned SKEW      = 1,
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_en,
    output logic [LANES-1:0] lane_rst,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [7:0]       block_cnt
);

    localparam int unsigned T      = (LANES - 1) * SKEW + BLOCK_LEN;
    localparam int unsigned CNT_W  = (clog2(T) < 1) ? 1 : clog2(T);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(T - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LANES-1:0]   r_lane_rst;
    logic               r_done;
    logic [7:0]         r_block_cnt;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_done_nxt;
    logic [LANES-1:0]   w_gate;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = repeat_en ? ST_RUN : ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Gates evaluate the counter value of the coming cycle so lane_rst can be
    // registered and still line up with c.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned RK = (LANES - 1 - k) * SKEW;
        skew_lane_gate #(
            .CNT_W (CNT_W)
        ) u_gate (
            .i_c   (w_cnt_nxt),
            .i_r   (CNT_W'(RK)),
            .i_len ((CNT_W + 1)'(BLOCK_LEN)),
            .o_rst (w_gate[k])
        );
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_lane_rst  <= '1;
            r_done      <= 1'b0;
            r_block_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lane_rst <= (w_state_nxt == ST_RUN) ? w_gate : '1;
            r_done     <= w_done_nxt;
            if (w_done_nxt) begin
                r_block_cnt <= r_block_cnt + 8'd1;
            end
        end
    end

    assign lane_rst  = r_lane_rst;
    assign ready     = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign done      = r_done;
    assign block_cnt = r_block_cnt;

endmodule

// File: tb/tb_skew_stream_seq.sv
`timescale 1ns/1ps
module tb_skew_stream_seq;

    logic       clock;
    logic       reset, start, abort, repeat_en;
    logic [3:0] lane_rst;
    logic       ready, busy, done;
    logic [7:0] block_cnt;

    logic       reset2, start2, abort2, rep2;
    logic [2:0] lr2;
    logic       rdy2, bsy2, dn2;
    logic [7:0] bc2;
    logic [0:0] lr3;
    logic       rdy3, bsy3, dn3;
    logic [7:0] bc3;

    int errors = 0;
    int checks = 0;
    bit main_done = 0;
    bit d2_done = 0;

    skew_stream_seq dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .repeat_en(repeat_en),
        .lane_rst(lane_rst), .ready(ready), .busy(busy), .done(done), .block_cnt(block_cnt)
    );

    skew_stream_seq #(.LANES(3), .SKEW(2), .BLOCK_LEN(2)) dut2 (
        .clock(clock), .reset(reset2), .start(start2), .abort(abort2), .repeat_en(rep2),
        .lane_rst(lr2), .ready(rdy2), .busy(bsy2), .done(dn2), .block_cnt(bc2)
    );

    skew_stream_seq #(.LANES(1), .SKEW(1), .BLOCK_LEN(3)) dut3 (
        .clock(clock), .reset(reset2), .start(start2), .abort(abort2), .repeat_en(rep2),
        .lane_rst(lr3), .ready(rdy3), .busy(bsy3), .done(dn3), .block_cnt(bc3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [3:0] lr;
        logic       run;
        logic       dn;
        logic [7:0] bc;
    } exp_t;

    typedef struct {
        logic [2:0] lr2;
        logic       dn2;
        logic       lr3;
        logic       dn3;
    } exp2_t;

    exp_t  q[$];
    exp2_t q2[$];

    logic [3:0] pat [7] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1110};
    logic [2:0] t2lr [8] = '{3'b011, 3'b011, 3'b101, 3'b101, 3'b110, 3'b110, 3'b111, 3'b111};
    logic       t2dn [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t3lr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       t3dn [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic [7:0] ebc = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Inputs are applied at the falling edge; the pushed entry is the output
    // expected just after the following rising edge.
    task automatic step(input logic rn, input logic s, input logic a, input logic rp,
                        input logic [3:0] lr, input logic run, input logic dn);
        exp_t e;
        @(negedge clock);
        reset = rn; start = s; abort = a; repeat_en = rp;
        if (!rn) ebc = 8'd0;
        else if (dn) ebc = ebc + 8'd1;
        e.lr = lr; e.run = run; e.dn = dn; e.bc = ebc;
        q.push_back(e);
    endtask

    task automatic step2(input logic rn, input logic s, input int k);
        exp2_t e;
        @(negedge clock);
        reset2 = rn; start2 = s;
        if (k < 0) begin
            e.lr2 = 3'b111; e.dn2 = 1'b0; e.lr3 = 1'b1; e.dn3 = 1'b0;
        end else begin
            e.lr2 = t2lr[k]; e.dn2 = t2dn[k]; e.lr3 = t3lr[k]; e.dn3 = t3dn[k];
        end
        q2.push_back(e);
    endtask

    task automatic single_block();
        step(1, 1, 0, 0, pat[0], 1, 0);
        for (int i = 1; i < 7; i++) step(1, 0, 0, 0, pat[i], 1, 0);
        step(1, 0, 0, 0, 4'b1111, 0, 1);
        step(1, 0, 0, 0, 4'b1111, 0, 0);
    endtask

    // Monitor for the default-parameter instance
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("lane_rst",  lane_rst,  e.lr);
                chk("ready",     ready,     !e.run);
                chk("busy",      busy,      e.run);
                chk("done",      done,      e.dn);
                chk("block_cnt", block_cnt, e.bc);
            end
        end
    end

    // Monitor for the swept-parameter instances
    initial begin
        exp2_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("sweep_lane_rst", lr2, e.lr2);
                chk("sweep_done",     dn2, e.dn2);
                chk("one_lane_rst",   lr3, e.lr3);
                chk("one_lane_done",  dn3, e.dn3);
            end
        end
    end

    // Main stimulus
    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
        step(0, 0, 0, 0, 4'b1111, 0, 0);
        step(0, 0, 0, 0, 4'b1111, 0, 0);
        step(1, 0, 0, 0, 4'b1111, 0, 0);

        single_block();

        // two back-to-back blocks; start during RUN and at completion is dropped
        step(1, 1, 0, 1, pat[0], 1, 0);
        for (int i = 1; i < 7; i++) step(1, 0, 0, 1, pat[i], 1, 0);
        step(1, 0, 0, 1, pat[0], 1, 1);
        for (int i = 1; i < 7; i++) step(1, (i == 3), 0, 0, pat[i], 1, 0);
        step(1, 1, 0, 0, 4'b1111, 0, 1);
        step(1, 0, 0, 0, 4'b1111, 0, 0);

        // abort at c=3
        step(1, 1, 0, 0, pat[0], 1, 0);
        for (int i = 1; i < 4; i++) step(1, 0, 0, 0, pat[i], 1, 0);
        step(1, 0, 1, 0, 4'b1111, 0, 0);
        step(1, 0, 0, 0, 4'b1111, 0, 0);

        // abort at c=T-1 beats completion and repeat
        step(1, 1, 0, 1, pat[0], 1, 0);
        for (int i = 1; i < 7; i++) step(1, 0, 0, 1, pat[i], 1, 0);
        step(1, 0, 1, 1, 4'b1111, 0, 0);
        step(1, 0, 0, 0, 4'b1111, 0, 0);

        // start+abort in IDLE, abort alone in IDLE
        step(1, 1, 1, 0, 4'b1111, 0, 0);
        step(1, 0, 1, 0, 4'b1111, 0, 0);
        step(1, 0, 0, 0, 4'b1111, 0, 0);

        // reset at c=2, then a clean block
        step(1, 1, 0, 0, pat[0], 1, 0);
        for (int i = 1; i < 3; i++) step(1, 0, 0, 0, pat[i], 1, 0);
        step(0, 0, 0, 0, 4'b1111, 0, 0);
        step(1, 0, 0, 0, 4'b1111, 0, 0);
        single_block();

        // 256 repeated blocks from zero: block_cnt passes 255 and wraps to 0
        step(0, 0, 0, 0, 4'b1111, 0, 0);
        step(1, 1, 0, 1, pat[0], 1, 0);
        for (int b = 0; b < 256; b++) begin
            for (int i = 1; i < 7; i++) step(1, 0, 0, 1, pat[i], 1, 0);
            if (b == 255) step(1, 0, 0, 0, 4'b1111, 0, 1);
            else          step(1, 0, 0, 1, pat[0], 1, 1);
        end
        step(1, 0, 0, 0, 4'b1111, 0, 0);
        main_done = 1;
    end

    // Parameter-sweep stimulus
    initial begin
        reset2 = 1'b0; start2 = 1'b0; abort2 = 1'b0; rep2 = 1'b0;
        step2(0, 0, -1);
        step2(0, 0, -1);
        step2(1, 0, -1);
        step2(1, 1, 0);
        for (int k = 1; k < 8; k++) step2(1, 0, k);
        d2_done = 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        wait (main_done && d2_done);
        repeat (3) @(posedge clock);
        #2;
        chk("queues_drained", q.size() + q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skew_stream_seq.md
SKEW_STREAM_SEQ -- requirements
Module: skew_stream_seq

Interface
REQ-001 Parameter LANES, default 4, SHALL set the number of input-stream lanes controlled (legal >= 1).
REQ-002 Parameter SKEW, default 1, SHALL set the cycles between successive lane releases (legal >= 1).
REQ-003 Parameter BLOCK_LEN, default 4, SHALL set the cycles each lane stays released per block (legal >= 1).
REQ-004 Derived constants: T = (LANES-1)*SKEW + BLOCK_LEN; CNT_W = clog2(T), minimum 1.
REQ-005 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 Port start, input, 1 bit: request to run one block; sampled only while ready=1.
REQ-008 Port abort, input, 1 bit: terminates a running block.
REQ-009 Port repeat_en, input, 1 bit: when high at end of block, the next block starts back-to-back.
REQ-010 Port lane_rst, output, LANES bits: 1 holds the lane's input mux in reset; 0 releases it.
REQ-011 Port ready, output, 1 bit: high in IDLE.
REQ-012 Port busy, output, 1 bit: high in RUN.
REQ-013 Port done, output, 1 bit: one-cycle pulse on block completion.
REQ-014 Port block_cnt, output, 8 bits: count of completed blocks.

Function
REQ-015 The block SHALL use two states: IDLE and RUN.
REQ-016 In IDLE, lane_rst SHALL be all ones, ready=1, busy=0.
REQ-017 In IDLE, start=1 and abort=0 at an edge SHALL enter RUN with cycle counter c=0.
REQ-018 In RUN, c SHALL increment by 1 per cycle, from 0 to T-1.
REQ-019 Release order SHALL be lane LANES-1 first, lane 0 last: r(k) = (LANES-1-k)*SKEW.
REQ-020 In RUN, lane_rst[k] SHALL be 0 exactly when r(k) <= c <= r(k)+BLOCK_LEN-1, and 1 otherwise.
REQ-021 lane_rst SHALL be a registered output, with no combinational path from any input.
REQ-022 At c=T-1 with repeat_en=0, the next cycle SHALL be IDLE and done=1 for that one cycle.
REQ-023 At c=T-1 with repeat_en=1, the next cycle SHALL be RUN with c=0 and done=1 for that one cycle.
REQ-024 block_cnt SHALL increment by one on each done pulse and wrap from 255 to 0.
REQ-025 abort=1 in RUN SHALL give IDLE next cycle with lane_rst all ones; no done pulse; block_cnt unchanged.
REQ-026 abort=1 in IDLE SHALL have no effect; abort and start together in IDLE SHALL leave the block in IDLE.
REQ-027 start in RUN SHALL be ignored and not queued.
REQ-028 abort at c=T-1 SHALL win over completion: no done pulse; IDLE next cycle regardless of repeat_en.
REQ-029 LANES=1 SHALL give a single lane released for c=0..BLOCK_LEN-1.

Reset
REQ-030 reset=0 at an edge SHALL force IDLE, c=0, lane_rst all ones, ready=1, busy=0, done=0, block_cnt=0.
REQ-031 Reset in mid-RUN SHALL take effect at the next edge, with no done pulse and no partial lane release afterward.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, RUN) and the clog2 helper function.
REQ-033 The per-lane window compare SHALL be one sub-module, skew_lane_gate, instantiated LANES times by generate; its inputs are c, r(k) and BLOCK_LEN, and its output is the next-cycle lane_rst bit.

Verification (defaults: LANES=4, SKEW=1, BLOCK_LEN=4, T=7)
REQ-034 Single block: pulse start in IDLE -> lane_rst sequence 0111, 0011, 0001, 0000, 1000, 1100, 1110, then 1111 with done=1 for one cycle; block_cnt=1.
REQ-035 Repeat mode: repeat_en=1 held for 2 blocks -> the second 0111 follows the first 1110 directly; done pulses 7 cycles apart; block_cnt=2.
REQ-036 Abort: abort at c=3 -> lane_rst=1111 and ready=1 next cycle; done never asserted; block_cnt unchanged.
REQ-037 Reset mid-run: reset=0 at c=2 -> all outputs at reset values next cycle; a new start then reproduces the REQ-034 sequence.
REQ-038 Parameter sweep: SKEW=2, LANES=3, BLOCK_LEN=2 (T=6) -> lane2 released c=0..1, lane1 c=2..3, lane0 c=4..5; done at the cycle after c=5.
REQ-039 Corner cases: start+abort together in IDLE -> stays IDLE; start during RUN -> ignored; block_cnt driven to 255 then one more block -> wraps to 0.
